// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keycode source: FSM state enums,
// Set-2 scancodes, HID codes and the scancode-to-HID map functions.
package ps2_pkg;

   typedef enum logic [1:0] {FR_IDLE, FR_DATA, FR_PARITY, FR_STOP} frame_state_e;
   typedef enum logic [1:0] {DEC_NORM, DEC_BRK, DEC_EXT, DEC_EXT_BRK} dec_state_e;

   localparam logic [7:0] SC_W      = 8'h1D;
   localparam logic [7:0] SC_A      = 8'h1C;
   localparam logic [7:0] SC_S      = 8'h1B;
   localparam logic [7:0] SC_D      = 8'h23;
   localparam logic [7:0] SC_ENTER  = 8'h5A;
   localparam logic [7:0] SC_SPACE  = 8'h29;
   localparam logic [7:0] SC_Z      = 8'h1A;
   localparam logic [7:0] SC_X      = 8'h22;
   localparam logic [7:0] SC_UP     = 8'h75;
   localparam logic [7:0] SC_LEFT   = 8'h6B;
   localparam logic [7:0] SC_DOWN   = 8'h72;
   localparam logic [7:0] SC_RIGHT  = 8'h74;
   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;

   localparam logic [7:0] KEY_NONE  = 8'd0;
   localparam logic [7:0] KEY_W     = 8'd26;
   localparam logic [7:0] KEY_A     = 8'd4;
   localparam logic [7:0] KEY_S     = 8'd22;
   localparam logic [7:0] KEY_D     = 8'd7;
   localparam logic [7:0] KEY_ENTER = 8'd40;
   localparam logic [7:0] KEY_SPACE = 8'd44;
   localparam logic [7:0] KEY_Z     = 8'd29;
   localparam logic [7:0] KEY_X     = 8'd27;

   // Plain (non-prefixed) scancode to HID; KEY_NONE for unmapped codes.
   function automatic logic [7:0] map_key(input logic [7:0] sc);
      case (sc)
         SC_W:     map_key = KEY_W;
         SC_A:     map_key = KEY_A;
         SC_S:     map_key = KEY_S;
         SC_D:     map_key = KEY_D;
         SC_ENTER: map_key = KEY_ENTER;
         SC_SPACE: map_key = KEY_SPACE;
         SC_Z:     map_key = KEY_Z;
         SC_X:     map_key = KEY_X;
         default:  map_key = KEY_NONE;
      endcase
   endfunction

   // E0-prefixed arrow scancode to HID; arrows alias W/A/S/D.
   function automatic logic [7:0] map_ext_key(input logic [7:0] sc);
      case (sc)
         SC_UP:    map_ext_key = KEY_W;
         SC_LEFT:  map_ext_key = KEY_A;
         SC_DOWN:  map_ext_key = KEY_S;
         SC_RIGHT: map_ext_key = KEY_D;
         default:  map_ext_key = KEY_NONE;
      endcase
   endfunction

endpackage

// File: rtl/ps2_keycode_source_if.sv
// Keycode bus between the PS/2 keycode source (master) and the game logic (slave).
interface ps2_keycode_source_if;
   logic [7:0] keycode;
   logic       key_valid;
   logic       frame_err;

   modport master (output keycode, key_valid, frame_err);
   modport slave  (input  keycode, key_valid, frame_err);
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: line synchronisers, falling-edge detect on ps2_clk,
// 11-bit frame FSM with odd-parity/stop check and a mid-frame timeout.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_done,
   output logic       frame_err
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
   logic                   clk_prev_q, clk_prev_d;
   frame_state_e           state_q, state_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic                   parity_q, parity_d;
   logic [CNT_W-1:0]       tmo_cnt_q, tmo_cnt_d;
   logic                   byte_done_q, byte_done_d;
   logic                   frame_err_q, frame_err_d;
   logic                   fall_c;
   logic                   data_c;

   assign fall_c    = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
   assign data_c    = data_sync_q[SYNC_STAGES-1];
   assign rx_byte   = shift_q;
   assign byte_done = byte_done_q;
   assign frame_err = frame_err_q;

   // Next-state: synchroniser shift, frame FSM, timeout counter.
   always_comb begin
      clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      parity_d    = parity_q;
      tmo_cnt_d   = '0;
      byte_done_d = 1'b0;
      frame_err_d = 1'b0;

      if (state_q != FR_IDLE) begin
         tmo_cnt_d = fall_c ? '0 : tmo_cnt_q + CNT_W'(1);
      end

      case (state_q)
         FR_IDLE: begin
            if (fall_c && !data_c) begin
               state_d   = FR_DATA;
               bit_cnt_d = 3'd0;
            end
         end
         FR_DATA: begin
            if (fall_c) begin
               shift_d   = {data_c, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = FR_PARITY;
               end
            end
         end
         FR_PARITY: begin
            if (fall_c) begin
               parity_d = data_c;
               state_d  = FR_STOP;
            end
         end
         FR_STOP: begin
            if (fall_c) begin
               if (data_c && (^{shift_q, parity_q})) begin
                  byte_done_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
               state_d = FR_IDLE;
            end
         end
         default: state_d = FR_IDLE;
      endcase

      // A stalled keyboard clock abandons the frame.
      if ((state_q != FR_IDLE) && !fall_c && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
         state_d     = FR_IDLE;
         tmo_cnt_d   = '0;
         frame_err_d = 1'b1;
         byte_done_d = 1'b0;
      end
   end

   // State register; idle-high lines reset to 1 so reset never fakes a falling edge.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         clk_prev_q  <= 1'b1;
         state_q     <= FR_IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'd0;
         parity_q    <= 1'b0;
         tmo_cnt_q   <= '0;
         byte_done_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         clk_prev_q  <= clk_prev_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         tmo_cnt_q   <= tmo_cnt_d;
         byte_done_q <= byte_done_d;
         frame_err_q <= frame_err_d;
      end
   end

endmodule

// File: rtl/ps2_keycode_source.sv
// PS/2 keycode source: turns Set-2 scancodes into held HID keycodes for the
// movement controller. Define PS2_ARROW_MAP_EN to map E0-prefixed arrow keys
// onto W/A/S/D; otherwise every E0-prefixed code is consumed and ignored.
module ps2_keycode_source
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   ps2_clk,
   input  logic                   ps2_data,
   ps2_keycode_source_if.master   kc_if
);

   logic [7:0] rx_byte;
   logic       rx_byte_done;
   logic       rx_frame_err;
   dec_state_e dec_q, dec_d;
   logic [7:0] keycode_q, keycode_d;
   logic       key_valid_q, key_valid_d;
   logic [7:0] hid_c;
`ifdef PS2_ARROW_MAP_EN
   logic [7:0] ext_hid_c;
`endif

   ps2_rx_frame #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) u_rx (
      .Clk       (Clk),
      .Reset     (Reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rx_byte   (rx_byte),
      .byte_done (rx_byte_done),
      .frame_err (rx_frame_err)
   );

   assign kc_if.keycode   = keycode_q;
   assign kc_if.key_valid = key_valid_q;
   assign kc_if.frame_err = rx_frame_err;

   // Byte decoder: prefix tracking, make/break handling, last-pressed-wins hold.
   always_comb begin
      dec_d       = dec_q;
      keycode_d   = keycode_q;
      key_valid_d = 1'b0;
      hid_c       = map_key(rx_byte);
`ifdef PS2_ARROW_MAP_EN
      ext_hid_c   = map_ext_key(rx_byte);
`endif

      if (rx_byte_done) begin
         case (dec_q)
            DEC_NORM: begin
               if (rx_byte == SC_BREAK) begin
                  dec_d = DEC_BRK;
               end else if (rx_byte == SC_EXT) begin
                  dec_d = DEC_EXT;
               end else if (hid_c != KEY_NONE) begin
                  keycode_d   = hid_c;
                  key_valid_d = 1'b1;
               end
            end
            DEC_BRK: begin
               if ((hid_c != KEY_NONE) && (hid_c == keycode_q)) begin
                  keycode_d = KEY_NONE;
               end
               dec_d = DEC_NORM;
            end
            DEC_EXT: begin
               if (rx_byte == SC_BREAK) begin
                  dec_d = DEC_EXT_BRK;
               end else begin
`ifdef PS2_ARROW_MAP_EN
                  if (ext_hid_c != KEY_NONE) begin
                     keycode_d   = ext_hid_c;
                     key_valid_d = 1'b1;
                  end
`endif
                  dec_d = DEC_NORM;
               end
            end
            DEC_EXT_BRK: begin
`ifdef PS2_ARROW_MAP_EN
               if ((ext_hid_c != KEY_NONE) && (ext_hid_c == keycode_q)) begin
                  keycode_d = KEY_NONE;
               end
`endif
               dec_d = DEC_NORM;
            end
            default: dec_d = DEC_NORM;
         endcase
      end
   end

   // Decoder state and registered outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         dec_q       <= DEC_NORM;
         keycode_q   <= KEY_NONE;
         key_valid_q <= 1'b0;
      end else begin
         dec_q       <= dec_d;
         keycode_q   <= keycode_d;
         key_valid_q <= key_valid_d;
      end
   end

endmodule

// File: tb/tb_ps2_keycode_source.sv
// Self-checking bench for ps2_keycode_source: directed vector table, hand-written
// multi-cycle corner cases (parity, timeout, extended codes, mid-frame reset)
// and random key events checked against an event-level model of held keys.
module tb_ps2_keycode_source;
   import ps2_pkg::*;

   localparam int unsigned TMO  = 400;
   localparam int          HALF = 10;
`ifdef PS2_ARROW_MAP_EN
   localparam bit ARROW = 1'b1;
`else
   localparam bit ARROW = 1'b0;
`endif

   logic Clk = 1'b0;
   logic Reset;
   logic ps2_clk;
   logic ps2_data;

   ps2_keycode_source_if kc_if ();

   ps2_keycode_source #(
      .TIMEOUT_CYCLES (TMO),
      .SYNC_STAGES    (2)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .kc_if    (kc_if.master)
   );

   always #5 Clk = ~Clk;

   int checks   = 0;
   int failures = 0;
   int kv_cnt   = 0;
   int err_cnt  = 0;
   int cyc      = 0;
   int last_fall_cyc = 0;
   int last_err_cyc  = 0;
   logic bd_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Pulse monitor: counts key_valid / frame_err cycles and checks their timing.
   always @(negedge Clk) begin
      cyc++;
      if (kc_if.key_valid === 1'b1) begin
         kv_cnt++;
         check("key_valid_one_cycle_after_byte_done", 32'(bd_prev), 32'd1);
      end
      if (kc_if.frame_err === 1'b1) begin
         err_cnt++;
         last_err_cyc = cyc;
      end
      if (kc_if.key_valid === 1'b1 || kc_if.frame_err === 1'b1) begin
         check("key_valid_frame_err_exclusive", 32'(kc_if.key_valid & kc_if.frame_err), 32'd0);
      end
      bd_prev = dut.rx_byte_done;
   end

   // Watchdog so the run always ends.
   initial begin
      repeat (95000) @(posedge Clk);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) @(negedge Clk);
   endtask

   // Drive nbits of a frame, LSB first, one keyboard clock period per bit.
   task automatic send_bits(input logic [10:0] bits, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         idle(HALF);
         ps2_clk = 1'b0;
         last_fall_cyc = cyc;
         idle(HALF);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par);
      logic p;
      p = (~^b) ^ bad_par;
      send_bits({1'b1, p, b, 1'b0}, 11);
      ps2_data = 1'b1;
      idle(2 * HALF);
   endtask

   task automatic send_key(input logic [7:0] sc, input bit brk, input bit ext);
      if (ext) send_frame(SC_EXT, 1'b0);
      if (brk) send_frame(SC_BREAK, 1'b0);
      send_frame(sc, 1'b0);
   endtask

   task automatic expect_ev(input string name, input logic [7:0] exp_kc, input int exp_kv,
                            input int exp_err, input int kv0, input int err0);
      check({name, "_keycode"},   32'(kc_if.keycode), 32'(exp_kc));
      check({name, "_key_valid"}, 32'(kv_cnt - kv0),  32'(exp_kv));
      check({name, "_frame_err"}, 32'(err_cnt - err0), 32'(exp_err));
   endtask

   // Reference key map, straight from the key table.
   function automatic logic [7:0] ref_map(input logic [7:0] sc);
      case (sc)
         8'h1D: return 8'd26;
         8'h1C: return 8'd4;
         8'h1B: return 8'd22;
         8'h23: return 8'd7;
         8'h5A: return 8'd40;
         8'h29: return 8'd44;
         8'h1A: return 8'd29;
         8'h22: return 8'd27;
         default: return 8'd0;
      endcase
   endfunction

   function automatic logic [7:0] ref_ext_map(input logic [7:0] sc);
      if (!ARROW) return 8'd0;
      case (sc)
         8'h75: return 8'd26;
         8'h6B: return 8'd4;
         8'h72: return 8'd22;
         8'h74: return 8'd7;
         default: return 8'd0;
      endcase
   endfunction

   typedef struct packed {
      logic [7:0] sc;
      logic       brk;
      logic [7:0] exp_kc;
      logic [1:0] exp_kv;
   } vec_t;

   vec_t tbl [0:19];
   logic [7:0] mapped_sc [0:7];
   logic [7:0] unmapped_sc [0:3];
   logic [7:0] ext_sc [0:4];

   initial begin
      int kv0, err0, waited, d, r;
      logic [7:0] sc, hid, held, held_sc;
      bit ext, brk;

      tbl[0]  = '{8'h1D, 1'b0, 8'd26, 2'd1};
      tbl[1]  = '{8'h1D, 1'b1, 8'd0,  2'd0};
      tbl[2]  = '{8'h1D, 1'b0, 8'd26, 2'd1};
      tbl[3]  = '{8'h1C, 1'b0, 8'd4,  2'd1};
      tbl[4]  = '{8'h1D, 1'b1, 8'd4,  2'd0};
      tbl[5]  = '{8'h1C, 1'b1, 8'd0,  2'd0};
      tbl[6]  = '{8'h5A, 1'b0, 8'd40, 2'd1};
      tbl[7]  = '{8'h5A, 1'b0, 8'd40, 2'd1};
      tbl[8]  = '{8'h15, 1'b0, 8'd40, 2'd0};
      tbl[9]  = '{8'h15, 1'b1, 8'd40, 2'd0};
      tbl[10] = '{8'h29, 1'b0, 8'd44, 2'd1};
      tbl[11] = '{8'h5A, 1'b1, 8'd44, 2'd0};
      tbl[12] = '{8'h29, 1'b1, 8'd0,  2'd0};
      tbl[13] = '{8'h1B, 1'b0, 8'd22, 2'd1};
      tbl[14] = '{8'h23, 1'b0, 8'd7,  2'd1};
      tbl[15] = '{8'h1A, 1'b0, 8'd29, 2'd1};
      tbl[16] = '{8'h22, 1'b0, 8'd27, 2'd1};
      tbl[17] = '{8'h22, 1'b1, 8'd0,  2'd0};
      tbl[18] = '{8'h1A, 1'b1, 8'd0,  2'd0};
      tbl[19] = '{8'h23, 1'b1, 8'd0,  2'd0};

      mapped_sc[0] = 8'h1D; mapped_sc[1] = 8'h1C; mapped_sc[2] = 8'h1B; mapped_sc[3] = 8'h23;
      mapped_sc[4] = 8'h5A; mapped_sc[5] = 8'h29; mapped_sc[6] = 8'h1A; mapped_sc[7] = 8'h22;
      unmapped_sc[0] = 8'h15; unmapped_sc[1] = 8'h76; unmapped_sc[2] = 8'h0D; unmapped_sc[3] = 8'h66;
      ext_sc[0] = 8'h75; ext_sc[1] = 8'h6B; ext_sc[2] = 8'h72; ext_sc[3] = 8'h74; ext_sc[4] = 8'h70;

      // Reset state
      Reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
      idle(5);
      Reset = 1'b0;
      idle(2);
      check("reset_keycode",   32'(kc_if.keycode),   32'd0);
      check("reset_key_valid", 32'(kc_if.key_valid), 32'd0);
      check("reset_frame_err", 32'(kc_if.frame_err), 32'd0);

      // Directed vector table
      for (int i = 0; i < 20; i++) begin
         kv0 = kv_cnt; err0 = err_cnt;
         send_key(tbl[i].sc, tbl[i].brk, 1'b0);
         expect_ev($sformatf("vec%0d", i), tbl[i].exp_kc, int'(tbl[i].exp_kv), 0, kv0, err0);
      end

      // Wrong parity on a D make
      kv0 = kv_cnt; err0 = err_cnt;
      send_frame(8'h23, 1'b1);
      expect_ev("bad_parity", 8'd0, 0, 1, kv0, err0);

      // Stalled frame: start bit plus four data bits, then silence
      kv0 = kv_cnt; err0 = err_cnt;
      send_bits({6'b0, 4'b1011, 1'b0}, 5);
      ps2_data = 1'b1;
      waited = 0;
      while (err_cnt == err0 && waited < int'(TMO) + 100) begin
         idle(1);
         waited++;
      end
      d = last_err_cyc - last_fall_cyc;
      check("timeout_seen", 32'(err_cnt - err0), 32'd1);
      check("timeout_delay_in_window", 32'(d >= int'(TMO) - 2 && d <= int'(TMO) + 8), 32'd1);
      idle(4);
      expect_ev("timeout_after", 8'd0, 0, 1, kv0, err0);
      kv0 = kv_cnt; err0 = err_cnt;
      send_key(8'h1B, 1'b0, 1'b0);
      expect_ev("after_timeout_S", 8'd22, 1, 0, kv0, err0);
      kv0 = kv_cnt; err0 = err_cnt;
      send_key(8'h1B, 1'b1, 1'b0);
      expect_ev("release_S", 8'd0, 0, 0, kv0, err0);

      // Extended codes
      kv0 = kv_cnt; err0 = err_cnt;
      send_key(8'h75, 1'b0, 1'b1);
      expect_ev("ext_up", ARROW ? 8'd26 : 8'd0, ARROW ? 1 : 0, 0, kv0, err0);
      kv0 = kv_cnt; err0 = err_cnt;
      send_key(8'h1C, 1'b0, 1'b0);
      expect_ev("after_ext_norm", 8'd4, 1, 0, kv0, err0);
      kv0 = kv_cnt; err0 = err_cnt;
      send_key(8'h75, 1'b1, 1'b1);
      expect_ev("ext_up_release_not_held", 8'd4, 0, 0, kv0, err0);
      kv0 = kv_cnt; err0 = err_cnt;
      send_key(8'h6B, 1'b0, 1'b1);
      expect_ev("ext_left", 8'd4, ARROW ? 1 : 0, 0, kv0, err0);
      kv0 = kv_cnt; err0 = err_cnt;
      send_key(8'h6B, 1'b1, 1'b1);
      expect_ev("ext_left_release", ARROW ? 8'd0 : 8'd4, 0, 0, kv0, err0);
      kv0 = kv_cnt; err0 = err_cnt;
      send_key(8'h1C, 1'b1, 1'b0);
      expect_ev("release_A", 8'd0, 0, 0, kv0, err0);

      // Reset in the middle of an A frame while W is held
      kv0 = kv_cnt; err0 = err_cnt;
      send_key(8'h1D, 1'b0, 1'b0);
      expect_ev("hold_W", 8'd26, 1, 0, kv0, err0);
      kv0 = kv_cnt; err0 = err_cnt;
      send_bits({2'b11, 8'h1C, 1'b0}, 6);
      Reset = 1'b1;
      idle(1);
      check("midframe_reset_keycode", 32'(kc_if.keycode), 32'd0);
      Reset = 1'b0;
      ps2_data = 1'b1;
      idle(int'(TMO) + 20);
      expect_ev("midframe_reset_quiet", 8'd0, 0, 0, kv0, err0);
      kv0 = kv_cnt; err0 = err_cnt;
      send_key(8'h1C, 1'b0, 1'b0);
      expect_ev("after_reset_A", 8'd4, 1, 0, kv0, err0);
      kv0 = kv_cnt; err0 = err_cnt;
      send_key(8'h1C, 1'b1, 1'b0);
      expect_ev("after_reset_release_A", 8'd0, 0, 0, kv0, err0);

      // Random key events against the held-key model
      held = 8'd0; held_sc = 8'h1D;
      for (int n = 0; n < 40; n++) begin
         kv0 = kv_cnt; err0 = err_cnt;
         r = int'($urandom_range(0, 9));
         if (r <= 3) begin
            sc = mapped_sc[$urandom_range(0, 7)];
            send_key(sc, 1'b0, 1'b0);
            held = ref_map(sc); held_sc = sc;
            expect_ev($sformatf("rnd%0d_press", n), held, 1, 0, kv0, err0);
         end else if (r <= 5) begin
            sc = ($urandom_range(0, 1) == 1) ? held_sc : mapped_sc[$urandom_range(0, 7)];
            send_key(sc, 1'b1, 1'b0);
            if (ref_map(sc) == held) held = 8'd0;
            expect_ev($sformatf("rnd%0d_release", n), held, 0, 0, kv0, err0);
         end else if (r == 6) begin
            sc = unmapped_sc[$urandom_range(0, 3)];
            brk = 1'($urandom_range(0, 1));
            send_key(sc, brk, 1'b0);
            expect_ev($sformatf("rnd%0d_unmapped", n), held, 0, 0, kv0, err0);
         end else if (r <= 8) begin
            sc = ext_sc[$urandom_range(0, 4)];
            ext = 1'b1;
            brk = (r == 8);
            send_key(sc, brk, ext);
            hid = ref_ext_map(sc);
            if (!brk && hid != 8'd0) held = hid;
            if (brk && hid != 8'd0 && hid == held) held = 8'd0;
            expect_ev($sformatf("rnd%0d_ext", n), held, (!brk && hid != 8'd0) ? 1 : 0, 0, kv0, err0);
         end else begin
            sc = mapped_sc[$urandom_range(0, 7)];
            send_frame(sc, 1'b1);
            expect_ev($sformatf("rnd%0d_badpar", n), held, 0, 1, kv0, err0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_keycode_source.md
Name: ps2_keycode_source

Overview:
- Producer side of the 8-bit `keycode` bus that the player-movement controller consumes.
- Receives PS/2 Set-2 scancodes from a keyboard and translates the movement and action keys into the USB-HID-style codes the game logic expects (W=26, A=4, S=22, D=7).
- Holds each code on `keycode` while the key is held, and returns `keycode` to 0 on key release.
- Sits between the board PS/2 pins and the game top level; it replaces the USB-host keycode path on PS/2 builds.

Parameters:
- TIMEOUT_CYCLES, 50000, number of Clk cycles without a PS/2 falling edge, mid-frame, before the frame is aborted (1 ms at 50 MHz).
- SYNC_STAGES, 2, number of flip-flop synchroniser stages on `ps2_clk` and on `ps2_data`; minimum 2.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock line, asynchronous to Clk.
- ps2_data  input  1  raw PS/2 data line, asynchronous to Clk.
- keycode  output  8  HID code of the currently held mapped key; 0 when no mapped key is held.
- key_valid  output  1  one-cycle pulse on each accepted make code, including typematic repeats.
- frame_err  output  1  one-cycle pulse on a parity error, a stop-bit error, or a timeout.

Behaviour:
- Reset and clock:
  - Reset is synchronous, active-high; clock is Clk.
  - Reset values: keycode=0, key_valid=0, frame_err=0. Both FSMs return to their idle state, the shift register is cleared, and the timeout counter is cleared.
  - Reset asserted mid-frame discards the partial frame; nothing is emitted.
- Synchroniser and edge detect:
  - Both PS/2 lines pass through SYNC_STAGES flip-flops.
  - A falling edge on the synchronised `ps2_clk` produces `fall` for exactly one cycle.
  - `ps2_data` is sampled only in `fall` cycles.
- Frame FSM (IDLE, DATA, PARITY, STOP):
  - IDLE: on `fall` with data=0 (start bit), go to DATA and set bit count=0. On `fall` with data=1, stay in IDLE and raise no error.
  - DATA: shift in 8 bits, LSB first; after the 8th bit, go to PARITY.
  - PARITY: capture the parity bit; go to STOP.
  - STOP: the frame is good when the stop bit is 1 and odd parity holds over the 8 data bits plus the parity bit. A good frame asserts byte_done for 1 cycle. A bad frame pulses frame_err and drops the byte. Either way, return to IDLE.
  - Timeout: in any non-IDLE state, a counter runs and clears on every `fall`. When it reaches TIMEOUT_CYCLES-1, pulse frame_err, go to IDLE, and emit no byte.
- Byte decode FSM (NORM, BRK, EXT, EXT_BRK), which acts only on byte_done:
  - NORM: 0xF0 goes to BRK, 0xE0 goes to EXT. A mapped make sets keycode=map and pulses key_valid. An unmapped byte is ignored.
  - BRK: if the byte maps to the current keycode, set keycode=0. Otherwise keycode is unchanged. Go to NORM.
  - EXT: 0xF0 goes to EXT_BRK. Any other byte is handled per the Optional Feature, then go to NORM.
  - EXT_BRK: handled per the Optional Feature; go to NORM.
- Latency: byte_done in cycle N makes keycode and key_valid visible in cycle N+1.
- Key map (scancode -> HID):
  - 0x1D -> 26 (W)
  - 0x1C -> 4 (A)
  - 0x1B -> 22 (S)
  - 0x23 -> 7 (D)
  - 0x5A -> 40 (Enter)
  - 0x29 -> 44 (Space)
  - 0x1A -> 29 (Z)
  - 0x22 -> 27 (X)
- Held-key rules:
  - A new make while another key is held overwrites keycode (last-pressed wins).
  - Releasing a key that is not the held key does not clear keycode.
  - A repeated make of the held key leaves keycode unchanged and pulses key_valid again.
- key_valid and frame_err are never asserted in the same cycle.

Optional Feature:
- Macro: PS2_ARROW_MAP_EN.
- When defined:
  - Extended make codes map as: E0 75 -> 26, E0 6B -> 4, E0 72 -> 22, E0 74 -> 7. The arrow keys then alias W/A/S/D.
  - Extended breaks follow the same held-key release rule as normal breaks.
  - Other extended codes are ignored.
- When undefined: every E0-prefixed make and break is consumed and ignored, and keycode is unaffected.

Decomposition:
- Package ps2_pkg holds:
  - the frame-state and decode-state enums;
  - the scancode localparams (SC_W, SC_A, SC_BREAK=0xF0, SC_EXT=0xE0, …);
  - the HID localparams (KEY_W=26, KEY_A=4, KEY_S=22, KEY_D=7, …).
- Sub-module ps2_rx_frame covers the synchroniser, edge detect, frame FSM and timeout. Its outputs are byte[7:0], byte_done and frame_err.
- The top level contains the decode FSM and the map function.

Test Plan:
- Send a frame for 0x1D (W) -> keycode=26 one cycle after byte_done, with a single key_valid pulse; then send F0,1D -> keycode=0 and no key_valid.
- Hold W, then press A (0x1C) -> keycode=4; then release W (F0,1D) -> keycode stays 4; then release A (F0,1C) -> keycode=0.
- Send a frame of 0x23 with a wrong parity bit -> one frame_err pulse, keycode stays 0, no key_valid.
- Drive the start bit plus 4 data bits, then stop toggling ps2_clk -> frame_err pulses after TIMEOUT_CYCLES; a following clean 0x1B frame gives keycode=22.
- Send E0,75 -> keycode=26 with PS2_ARROW_MAP_EN defined; keycode=0 with the macro undefined; in both builds the decoder returns to NORM.
- Assert Reset after the 6th bit of a 0x1C frame while keycode=26 -> keycode=0 in the next cycle; the partial frame produces no key_valid and no frame_err.
